// File: rtl/adder_self_test.sv
// adder_self_test: exhaustive stimulus generator and checker for a 4-bit adder/subtractor
module adder_self_test #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic [8:0] dut_sw,
    input  logic [4:0] dut_ledr,
    output logic [4:0] exp_ledr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_fail,
    output logic [4:0] first_fail_ledr
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic fail_seen, mismatch, launch;
    assign exp_ledr = {1'b0, dut_sw[4:1]} + {1'b0, dut_sw[8:5] ^ {4{dut_sw[0]}}} + {4'b0, dut_sw[0]};
    assign mismatch = dut_ledr != exp_ledr;
    assign busy = state == APPLY || state == CHECK;
    assign done = state == DONE;
    assign pass = done && err_count == 10'd0;
    // state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // next state; launch marks an accepted start that clears the run registers
    always_comb begin
        state_nxt = state;
        launch = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                state_nxt = APPLY;
                launch = 1'b1;
            end
            APPLY: state_nxt = cnt == LAST ? CHECK : APPLY;
            CHECK: state_nxt = (dut_sw == 9'h1ff || (mismatch && STOP_ON_FAIL)) ? DONE : APPLY;
            default: state_nxt = IDLE;
        endcase
    end
    // vector counter, settle timer, error tally and first-failure capture
    always_ff @(posedge CLOCK_50) begin
        if (reset || launch) begin
            dut_sw <= '0;
            cnt <= '0;
            err_count <= '0;
            first_fail <= '0;
            first_fail_ledr <= '0;
            fail_seen <= 1'b0;
        end else if (state == APPLY) begin
            cnt <= cnt + 1'b1;
        end else if (state == CHECK) begin
            if (mismatch) begin
                err_count <= err_count + 10'd1;
                if (!fail_seen) begin
                    first_fail <= dut_sw;
                    first_fail_ledr <= dut_ledr;
                    fail_seen <= 1'b1;
                end
            end
            if (state_nxt == APPLY) begin
                dut_sw <= dut_sw + 9'd1;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adder_self_test.sv
// tb_adder_self_test: randomized fault-injection bench with an arithmetic run model
module tb_adder_self_test;
    localparam int S = 2;
    localparam int P = S + 1;
    localparam int DUR = 512 * P;
    logic clk = 0, reset = 1, start = 0, start_s = 0;
    logic [8:0] dut_sw, first_fail, dut_sw_s, first_fail_s;
    logic [4:0] dut_ledr, exp_ledr, first_fail_ledr, dut_ledr_s, exp_ledr_s, first_fail_ledr_s;
    logic busy, done, pass, busy_s, done_s, pass_s;
    logic [9:0] err_count, err_count_s;
    int n_chk = 0, n_pass = 0, mode = 0, busy_cnt = 0, busy_s_cnt = 0;
    bit bad[512];
    logic [4:0] bmask[512];
    int cum[513], run_cum[513];
    int first_v = -1, run_first_v = -1;
    logic [4:0] first_ledr = 0, run_first_ledr = 0;
    bit m_act = 0, chk_en = 0;
    int m_c = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] golden(input logic [8:0] sw);
        int a, b, r;
        a = int'(sw[4:1]);
        b = int'(sw[8:5]);
        if (!sw[0]) r = a + b;
        else r = (a >= b ? 16 : 0) + ((a - b) & 15);
        return 5'(r);
    endfunction

    function automatic logic [4:0] fault(input int m, input logic [8:0] sw);
        logic [4:0] g;
        g = golden(sw);
        if (m == 1) return g & 5'b01111;
        if (m == 2) return g ^ 5'b00001;
        if (m == 3 && bad[sw]) return g ^ bmask[sw];
        return g;
    endfunction

    assign dut_ledr = fault(mode, dut_sw);
    assign dut_ledr_s = fault(mode, dut_sw_s);

    adder_self_test #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b0)) u_dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .dut_sw(dut_sw), .dut_ledr(dut_ledr),
        .exp_ledr(exp_ledr), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail), .first_fail_ledr(first_fail_ledr));

    adder_self_test #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b1)) u_stop (
        .CLOCK_50(clk), .reset(reset), .start(start_s), .dut_sw(dut_sw_s), .dut_ledr(dut_ledr_s),
        .exp_ledr(exp_ledr_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
        .first_fail(first_fail_s), .first_fail_ledr(first_fail_ledr_s));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // run model: cycles elapsed since the accepted start edge, snapshot of the fault table
    always @(posedge clk) begin
        if (reset) m_act <= 0;
        else if (start && (!m_act || m_c >= DUR)) begin
            m_act <= 1;
            m_c <= 0;
            run_cum <= cum;
            run_first_v <= first_v;
            run_first_ledr <= first_ledr;
        end else m_c <= m_c + 1;
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy_s) busy_s_cnt++;
    end

    // per-cycle compare of the main instance against the model
    always @(negedge clk) begin : cmp
        int n;
        bit d;
        if (chk_en) begin
            chk("exp_ledr", exp_ledr, golden(dut_sw));
            if (!m_act) begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_pass", pass, 0);
                chk("idle_sw", dut_sw, 0);
                chk("idle_err", err_count, 0);
                chk("idle_ff", first_fail, 0);
                chk("idle_ffl", first_fail_ledr, 0);
            end else begin
                d = m_c >= DUR;
                n = d ? 512 : m_c / P;
                chk("run_busy", busy, !d);
                chk("run_done", done, d);
                chk("run_sw", dut_sw, d ? 511 : m_c / P);
                chk("run_err", err_count, run_cum[n]);
                chk("run_pass", pass, d && run_cum[512] == 0);
                chk("run_ff", first_fail, (run_first_v >= 0 && run_first_v < n) ? run_first_v : 0);
                chk("run_ffl", first_fail_ledr, (run_first_v >= 0 && run_first_v < n) ? run_first_ledr : 0);
            end
        end
    end

    task automatic prep(input int m);
        logic [4:0] g;
        mode = 0;
        #1;
        if (m == 3) begin
            for (int v = 0; v < 512; v++) begin
                bad[v] = $urandom_range(0, 15) == 0;
                bmask[v] = 5'($urandom_range(1, 31));
            end
            bad[$urandom_range(0, 511)] = 1;
        end
        mode = m;
        cum[0] = 0;
        first_v = -1;
        for (int v = 0; v < 512; v++) begin
            g = fault(m, 9'(v));
            cum[v+1] = cum[v] + (g != golden(9'(v)) ? 1 : 0);
            if (g != golden(9'(v)) && first_v < 0) begin
                first_v = v;
                first_ledr = g;
            end
        end
    endtask

    task automatic wait_done(input bit which);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (which ? done_s : done) break;
        end
        chk("run_timeout", which ? done_s : done, 1);
    endtask

    task automatic run(input int m, input bit poke);
        prep(m);
        @(posedge clk);
        #1 busy_cnt = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        if (poke) begin
            repeat ($urandom_range(20, 1400)) @(posedge clk);
            #1 start = 1;
            @(posedge clk);
            #1 start = 0;
        end
        wait_done(0);
        chk("busy_len", busy_cnt, DUR);
    endtask

    task automatic run_stop(input int m);
        prep(m);
        @(posedge clk);
        #1 busy_s_cnt = 0;
        start_s = 1;
        @(posedge clk);
        #1 start_s = 0;
        wait_done(1);
        chk("stop_busy_len", busy_s_cnt, (first_v + 1) * P);
        chk("stop_err", err_count_s, 1);
        chk("stop_ff", first_fail_s, first_v);
        chk("stop_ffl", first_fail_ledr_s, first_ledr);
        chk("stop_pass", pass_s, 0);
    endtask

    initial begin
        chk("pin_5m3", golden(9'd107), 5'b10010);
        chk("pin_3m5", golden(9'd167), 5'b01110);
        chk("pin_15p15", golden(9'd510), 5'b11110);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_sw", dut_sw, 0);
        chk("rst_exp", exp_ledr, 0);
        chk("rst_busy", busy, 0);
        run(0, 0);
        chk("good_pass", pass, 1);
        chk("good_err", err_count, 0);
        chk("good_ff", first_fail, 0);
        run(1, 0);
        chk("pin_carry_cnt", cum[512], 256);
        chk("c4_err", err_count, 256);
        chk("c4_ff", first_fail, 9'h001);
        chk("c4_ffl", first_fail_ledr, 5'b00000);
        chk("c4_pass", pass, 0);
        run(2, 1);
        chk("inv0_err", err_count, 512);
        chk("inv0_ff", first_fail, 9'h000);
        chk("inv0_ffl", first_fail_ledr, 5'b00001);
        for (int k = 0; k < 2; k++) run(3, 1);
        run_stop(1);
        chk("stop_c4_busy", busy_s_cnt, 6);
        chk("stop_c4_done", done_s, 1);
        run_stop(3);
        prep(0);
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dut_sw == 9'd200) break;
        end
        chk("reach_200", dut_sw, 200);
        @(posedge clk);
        #1 reset = 1;
        start = 1;
        @(posedge clk);
        #1 reset = 0;
        start = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_sw", dut_sw, 0);
        chk("midrst_done", done, 0);
        run(0, 0);
        chk("after_rst_pass", pass, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adder_self_test.md
# adder_self_test

Exhaustive stimulus generator and checker for the 4-bit adder/subtractor board block. It drives the 9-bit switch-format operand bus `{b[3:0], a[3:0], cin}` into the device under test (DUT). It samples the DUT's 5-bit LED result, compares it against an internal golden model, and reports pass/fail, an error count, and the first failing vector. It is the initiating end of the adder's SW/LEDR interface and replaces manual switch toggling on the board.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `STOP_ON_FAIL`, default 0: 1 = end the run at the first mismatch.

Ports:
- `CLOCK_50`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `dut_sw`  out  9  stimulus to DUT SW: [0]=cin, [4:1]=a, [8:5]=b
- `dut_ledr`  in  5  DUT LEDR: [3:0]=sum, [4]=carry-out
- `exp_ledr`  out  5  golden result for current `dut_sw` (combinational, debug)
- `busy`  out  1  run in progress
- `done`  out  1  run finished; held until restart or reset
- `pass`  out  1  valid when `done`: 1 iff `err_count`==0
- `err_count`  out  10  number of mismatching vectors (0..512)
- `first_fail`  out  9  `dut_sw` value of the first mismatch
- `first_fail_ledr`  out  5  `dut_ledr` captured at the first mismatch

## Operation
- Golden model, 5-bit modular: `exp_ledr = a + (b ^ {4{cin}}) + cin`.
  - cin=0 gives add; cin=1 gives a−b, with carry-out = 1 iff a≥b.
- Vector order: `dut_sw` counts 0,1,…,511 (cin is the LSB), 512 vectors total.
- FSM states:
  - IDLE: `start` → APPLY. Entering APPLY loads `dut_sw`=0, `err_count`=0, `first_fail`=0, `first_fail_ledr`=0, `fail_seen`=0, settle counter=0, `done`=0, `pass`=0, `busy`=1.
  - APPLY: settle counter increments each cycle; when it equals `SETTLE_CYCLES`−1 → CHECK.
  - CHECK: compare `dut_ledr` with `exp_ledr`.
    - On mismatch: `err_count`+1. If `fail_seen`=0, capture `first_fail`=`dut_sw` and `first_fail_ledr`=`dut_ledr`, then set `fail_seen`.
    - Next state:
      - → DONE if `dut_sw`==511, or on a mismatch with `STOP_ON_FAIL`=1.
      - Otherwise `dut_sw`+1, counter cleared, → APPLY.
  - DONE: `busy`=0, `done`=1, `pass`=(final `err_count`==0). `start` → APPLY, with the same clears as from IDLE.
- `start` in APPLY or CHECK is ignored. `dut_ledr` is ignored outside CHECK.
- `err_count` does not wrap: its maximum is 512, which fits in 10 bits.
- `dut_sw` holds its last value in DONE.

## Timing
- Reset values, applied at the next edge from any state including mid-run: state IDLE; all outputs 0 (`dut_sw`, `busy`, `done`, `pass`, `err_count`, `first_fail`, `first_fail_ledr`). `exp_ledr` then reflects `dut_sw`=0, i.e. 0.
- `reset` has priority over `start` in the same cycle.
- `start` high at edge k (in IDLE or DONE): after edge k, `busy`=1 and `dut_sw`=0.
- Each vector occupies exactly `SETTLE_CYCLES`+1 cycles: `SETTLE_CYCLES` in APPLY plus 1 in CHECK.
- The DUT sample is taken on the last cycle of each vector, `SETTLE_CYCLES` cycles after `dut_sw` changed.
- Full run: `busy` is high for 512×(`SETTLE_CYCLES`+1) cycles; `done`/`pass` rise and `busy` falls on the same edge.
- Early stop after a mismatch at vector i: `busy` is high for (i+1)×(`SETTLE_CYCLES`+1) cycles.
- `err_count` and the first-fail registers update on the CHECK edge.

## Test plan
- Correct behavioural adder as DUT, `SETTLE_CYCLES`=2: `done` rises 1536 cycles after `start`; `pass`=1, `err_count`=0, `first_fail`=0.
- DUT with LEDR[4] stuck at 0: `err_count`=256 (120 add + 136 subtract carries), `first_fail`=9'h001, `first_fail_ledr`=5'b00000 (expected 5'b10000), `pass`=0.
- DUT with LEDR[0] inverted: `err_count`=512, `first_fail`=9'h000, `first_fail_ledr`=5'b00001.
- `STOP_ON_FAIL`=1 with LEDR[4] stuck at 0, `SETTLE_CYCLES`=2: `busy` lasts 6 cycles; `err_count`=1, `first_fail`=9'h001, `done`=1.
- Spot-check the golden model:
  - `dut_sw` with a=5, b=3, cin=1 → `exp_ledr`=5'b10010.
  - a=3, b=5, cin=1 → 5'b01110.
  - a=15, b=15, cin=0 → 5'b11110.
- Reset and start handling:
  - Pulse `reset` at vector 200 → next edge all outputs 0, state IDLE.
  - Then pulse `start` → full run from `dut_sw`=0.
  - `start` pulsed mid-run → no effect on the vector sequence or counts.
  - `start` in DONE → counters cleared and a new run starts.
